// File: rtl/rv_lsu.sv
// rtl/rv_lsu.sv - RV32I load/store unit bridging CPU byte accesses onto an aligned memory bus
//
// Accepts one load/store at a time, splits word-crossing accesses into two
// aligned bus beats (or faults them when ALLOW_MISALIGNED = 0), positions
// store data on the byte lanes, and reassembles/extends load data.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        CPU request handshake (ready only in IDLE)
//   req_write, req_funct3      access kind and RV32I funct3 size/sign encoding
//   req_addr, req_wdata        byte address, right-aligned store data
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata, rsp_fault       extended load data / fault flag, held until next response
//   mem_req_valid/mem_req_ready  bus beat handshake
//   mem_addr, mem_wmask, mem_wdata  aligned beat address, lane strobes, lane data
//   mem_rvalid, mem_rdata      in-order read data return
module rv_lsu #(
  parameter int DATA_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_fault,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [31:0]         mem_addr,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_WAIT0,
    S_ISSUE1,
    S_WAIT1,
    S_RESP
  } state_t;

  // Access size in bytes from funct3[1:0]
  function automatic logic [3:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    size_of = 4'd1;
      2'd1:    size_of = 4'd2;
      default: size_of = 4'd4;
    endcase
  endfunction

  function automatic logic is_illegal(input logic wr, input logic [2:0] f3);
    if (wr) is_illegal = (f3 > 3'd2);
    else    is_illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  // Number of access bytes that fit in the first beat
  function automatic logic [3:0] beat0_len(input logic [OFF_W-1:0] off, input logic [3:0] size);
    logic [3:0] room;
    room = 4'(BYTES) - 4'(off);
    beat0_len = (size < room) ? size : room;
  endfunction

  function automatic logic [BYTES-1:0] beat0_mask(input logic [OFF_W-1:0] off, input logic [3:0] size);
    for (int i = 0; i < BYTES; i++) begin
      beat0_mask[i] = (i >= int'(off)) && (i < int'(off) + int'(size));
    end
  endfunction

  function automatic logic [BYTES-1:0] beat1_mask(input logic [OFF_W-1:0] off, input logic [3:0] size);
    for (int i = 0; i < BYTES; i++) begin
      beat1_mask[i] = (i < int'(off) + int'(size) - BYTES);
    end
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'd0:    extend = {{24{v[7]}}, v[7:0]};
      3'd1:    extend = {{16{v[15]}}, v[15:0]};
      3'd4:    extend = {24'd0, v[7:0]};
      3'd5:    extend = {16'd0, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              cross_q, cross_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [BYTES-1:0]  mem_wmask_q, mem_wmask_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_fault_q, rsp_fault_d;

  // Decode of the incoming request (used only on acceptance)
  logic [OFF_W-1:0]  req_off;
  logic [3:0]        req_size;
  logic              req_cross;
  logic              req_fault;
  assign req_off   = req_addr[OFF_W-1:0];
  assign req_size  = size_of(req_funct3);
  assign req_cross = (4'(req_off) + req_size) > 4'(BYTES);
  assign req_fault = is_illegal(req_write, req_funct3) || (req_cross && (ALLOW_MISALIGNED == 0));

  // Decode of the latched access
  logic [3:0]  cur_size;
  logic [3:0]  cur_n0;
  logic [31:0] ld_beat0;
  logic [31:0] ld_beat1;
  assign cur_size = size_of(funct3_q);
  assign cur_n0   = beat0_len(off_q, cur_size);
  // Beat 0 bytes land at the bottom of the assembly word; beat 1 bytes stack above them.
  assign ld_beat0 = 32'(mem_rdata >> {off_q, 3'b000});
  assign ld_beat1 = asm_q | (mem_rdata[31:0] << {cur_n0, 3'b000});

  always_comb begin
    state_d         = state_q;
    write_d         = write_q;
    funct3_d        = funct3_q;
    off_d           = off_q;
    cross_d         = cross_q;
    wdata_d         = wdata_q;
    asm_d           = asm_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    mem_wmask_d     = mem_wmask_q;
    mem_wdata_d     = mem_wdata_q;
    rsp_valid_d     = 1'b0;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_fault_d     = rsp_fault_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          off_d    = req_off;
          cross_d  = req_cross;
          wdata_d  = req_wdata;
          asm_d    = 32'd0;
          if (req_fault) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d         = S_ISSUE0;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
            mem_wmask_d     = req_write ? beat0_mask(req_off, req_size) : '0;
            mem_wdata_d     = req_write ? (DATA_W'(req_wdata) << {req_off, 3'b000}) : '0;
          end
        end
      end

      S_ISSUE0: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          if (!write_q) begin
            state_d = S_WAIT0;
          end else if (cross_q) begin
            // Remaining upper store bytes start at lane 0 of the next bus word
            state_d         = S_ISSUE1;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = mem_addr_q + 32'(BYTES);
            mem_wmask_d     = beat1_mask(off_q, cur_size);
            mem_wdata_d     = DATA_W'(wdata_q >> {cur_n0, 3'b000});
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b0;
            rsp_rdata_d = 32'd0;
          end
        end
      end

      S_WAIT0: begin
        if (mem_rvalid) begin
          asm_d = ld_beat0;
          if (cross_q) begin
            state_d         = S_ISSUE1;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = mem_addr_q + 32'(BYTES);
            mem_wmask_d     = '0;
            mem_wdata_d     = '0;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b0;
            rsp_rdata_d = extend(funct3_q, ld_beat0);
          end
        end
      end

      S_ISSUE1: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          if (write_q) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b0;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d = S_WAIT1;
          end
        end
      end

      S_WAIT1: begin
        if (mem_rvalid) begin
          asm_d       = ld_beat1;
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b0;
          rsp_rdata_d = extend(funct3_q, ld_beat1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      write_q         <= 1'b0;
      funct3_q        <= 3'd0;
      off_q           <= '0;
      cross_q         <= 1'b0;
      wdata_q         <= 32'd0;
      asm_q           <= 32'd0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= 32'd0;
      mem_wmask_q     <= '0;
      mem_wdata_q     <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= 32'd0;
      rsp_fault_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      write_q         <= write_d;
      funct3_q        <= funct3_d;
      off_q           <= off_d;
      cross_q         <= cross_d;
      wdata_q         <= wdata_d;
      asm_q           <= asm_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_wmask_q     <= mem_wmask_d;
      mem_wdata_q     <= mem_wdata_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_fault_q     <= rsp_fault_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_fault     = rsp_fault_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wmask     = mem_wmask_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: doc/rv_lsu.md
RV_LSU -- requirements
Module: rv_lsu

Interface
REQ-001 Parameter DATA_W, default 32, memory bus width in bits; legal values 32 and 64.
REQ-002 Parameter ALLOW_MISALIGNED, default 1; 1 splits word-crossing accesses into two beats, 0 faults them.
REQ-003 Derived BYTES = DATA_W/8 and OFF_W = log2(BYTES).
REQ-004 clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  CPU access request.
REQ-007 req_ready  output  1  LSU can accept a request.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  RV32I funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores 0 SB, 1 SH, 2 SW.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 rsp_valid  output  1  single-cycle completion pulse.
REQ-013 rsp_rdata  output  32  extended load result; 0 for stores and faults.
REQ-014 rsp_fault  output  1  qualified by rsp_valid; illegal funct3 or disallowed misalignment.
REQ-015 mem_req_valid  output  1  bus beat request.
REQ-016 mem_req_ready  input  1  bus accepts beat.
REQ-017 mem_addr  output  32  beat address, low OFF_W bits always 0.
REQ-018 mem_wmask  output  BYTES  byte-lane write strobes; all 0 for reads.
REQ-019 mem_wdata  output  DATA_W  lane-positioned store data.
REQ-020 mem_rvalid  input  1  read data valid, one per accepted read beat, in order.
REQ-021 mem_rdata  input  DATA_W  read data.

Function
REQ-022 States IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP; one request outstanding at most.
REQ-023 req_ready = 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1; all request fields are latched on acceptance.
REQ-024 Size = 1/2/4 bytes from funct3[1:0]; off = addr[OFF_W-1:0]; the access crosses when off + size > BYTES.
REQ-025 Illegal when load funct3 is 3/6/7 or store funct3 > 2; illegal, or crossing with ALLOW_MISALIGNED = 0, goes IDLE->RESP with rsp_fault = 1 and no bus beat.
REQ-026 A legal access goes IDLE->ISSUE0; mem_req_valid is registered and held with stable addr/mask/data until mem_req_ready.
REQ-027 Beat 0 uses mem_addr = addr with the low bits cleared and covers lanes off..min(off+size, BYTES)-1; beat 1 uses mem_addr = beat-0 address + BYTES and covers lanes 0..(off+size-BYTES-1).
REQ-028 Store lane data is req_wdata shifted left by 8*off bits (modulo the bus); beat 1 carries the remaining upper bytes starting at lane 0.
REQ-029 Store transitions: ISSUE0 handshake -> ISSUE1 if crossing, else RESP; ISSUE1 handshake -> RESP.
REQ-030 Load transitions: ISSUE0 handshake -> WAIT0; WAIT0 mem_rvalid -> ISSUE1 if crossing, else RESP; ISSUE1 handshake -> WAIT1; WAIT1 mem_rvalid -> RESP.
REQ-031 Load bytes are captured on mem_rvalid into a 32-bit assembly register, beat-0 bytes low and beat-1 bytes above them, then sign-extended (funct3 0/1) or zero-extended (4/5).
REQ-032 RESP asserts rsp_valid for exactly one cycle, then returns to IDLE; earliest new acceptance is the cycle after RESP.
REQ-033 Minimum latency from acceptance to rsp_valid: fault 1 cycle; aligned store 2 cycles with mem_req_ready = 1; aligned load 3 cycles with mem_rvalid in the cycle after the handshake.
REQ-034 mem_rvalid outside WAIT0/WAIT1 is ignored.
REQ-035 rsp_rdata and rsp_fault hold their values until the next RESP.

Reset
REQ-036 On reset the state is IDLE; mem_req_valid, rsp_valid, rsp_fault, and mem_wmask are 0; rsp_rdata, mem_addr, and mem_wdata are 0.
REQ-037 Reset in any state abandons the access without a response; a late mem_rvalid after reset is ignored; req_ready = 1 in the cycle after reset is deasserted.

Verification
REQ-038 DATA_W=32, LW 0x100, mem_rdata 0xDEADBEEF -> one beat at addr 0x100 with mask 0000; rsp_rdata 0xDEADBEEF, rsp_fault 0.
REQ-039 LB 0x103, mem_rdata 0x80000000 -> rsp_rdata 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-040 ALLOW_MISALIGNED=1, SW 0x102 with data 0x11223344 -> beat 0: addr 0x100, mask 1100, wdata[31:16] 0x3344; beat 1: addr 0x104, mask 0011, wdata[15:0] 0x1122; one rsp_valid.
REQ-041 ALLOW_MISALIGNED=1, LH 0x103, beats returning 0xAB000000 then 0x000000CD -> rsp_rdata 0xFFFFCDAB.
REQ-042 ALLOW_MISALIGNED=0, LW 0x101 -> rsp_fault 1 one cycle after acceptance; mem_req_valid never asserted; funct3 3 gives the same result.
REQ-043 DATA_W=64, SW 0x104 -> one beat at addr 0x100 with mask 0xF0; mem_req_ready held 0 for 3 cycles -> addr, mask, and data stay stable; reset during WAIT0 -> IDLE, late mem_rvalid ignored.
